mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide, one bit per cycle, with a FINISH cycle that sign-corrects and loads Hi/Lo.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultStart,
  input  logic             DivStart,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  // acc carries one guard bit so the Booth add/subtract of the most negative
  // multiplicand cannot overflow; for divide it holds the partial remainder.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mcand;
  logic             q_1;
  logic             is_div, neg_quo, neg_rem;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             done_reg, div_zero_reg;

  logic             accept_mult, accept_div, reject_div, last_iter;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shifted, div_diff;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    accept_mult = (state == IDLE) && MultStart;
    accept_div  = (state == IDLE) && !MultStart && DivStart && (B != '0);
    reject_div  = (state == IDLE) && !MultStart && DivStart && (B == '0);
    last_iter   = (count == CNT_W'(WIDTH - 1));
    a_mag       = A[WIDTH-1] ? -A : A;
    b_mag       = B[WIDTH-1] ? -B : B;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_mult)     state_next = MULT;
        else if (accept_div) state_next = DIV;
      end
      MULT:    if (last_iter) state_next = FINISH;
      DIV:     if (last_iter) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    booth_sum = acc;
    case ({mq[0], q_1})
      2'b01:   booth_sum = acc + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = acc - {mcand[WIDTH-1], mcand};
      default: booth_sum = acc;
    endcase
    div_shifted = {acc[WIDTH-1:0], mq[WIDTH-1]};
    div_diff    = div_shifted - {1'b0, mcand};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      acc          <= '0;
      mq           <= '0;
      mcand        <= '0;
      q_1          <= 1'b0;
      is_div       <= 1'b0;
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state        <= state_next;
      done_reg     <= 1'b0;
      div_zero_reg <= reject_div;
      case (state)
        IDLE: begin
          count <= '0;
          if (accept_mult) begin
            acc    <= '0;
            mq     <= B;
            mcand  <= A;
            q_1    <= 1'b0;
            is_div <= 1'b0;
          end else if (accept_div) begin
            acc     <= '0;
            mq      <= a_mag;
            mcand   <= b_mag;
            q_1     <= 1'b0;
            is_div  <= 1'b1;
            neg_quo <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_rem <= A[WIDTH-1];
          end
        end
        MULT: begin
          // Arithmetic shift of {acc, mq, q_1} after the Booth add/subtract.
          acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          mq    <= {booth_sum[0], mq[WIDTH-1:1]};
          q_1   <= mq[0];
          count <= count + CNT_W'(1);
        end
        DIV: begin
          acc   <= div_diff[WIDTH] ? {1'b0, div_shifted[WIDTH-1:0]}
                                   : {1'b0, div_diff[WIDTH-1:0]};
          mq    <= {mq[WIDTH-2:0], ~div_diff[WIDTH]};
          count <= count + CNT_W'(1);
        end
        FINISH: begin
          done_reg <= 1'b1;
          if (is_div) begin
            lo_reg <= neg_quo ? -mq : mq;
            hi_reg <= neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          end else begin
            lo_reg <= mq;
            hi_reg <= acc[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign Hi      = hi_reg;
  assign Lo      = lo_reg;
  assign Busy    = (state != IDLE);
  assign Done    = done_reg;
  assign DivZero = div_zero_reg;

endmodule
